// File: rtl/fdiv.sv
// Multi-cycle IEEE-754 single-precision divider (y = x1 / x2), restoring, one quotient bit per cycle.
// Optional macro FDIV_RNE_EN selects round-to-nearest-even; default build truncates.
module fdiv (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_NORM = 2'd2, S_DONE = 2'd3} state_e;
  typedef enum logic [1:0] {SP_NONE = 2'd0, SP_NAN = 2'd1, SP_INF = 2'd2, SP_ZERO = 2'd3} spec_e;

`ifdef FDIV_RNE_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  // Special-case decode; denormals are flushed to zero by treating exp==0 as zero.
  function automatic spec_e classify(input logic [31:0] a, input logic [31:0] b);
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    zero_a = (a[30:23] == 8'h00);
    zero_b = (b[30:23] == 8'h00);
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      classify = SP_NAN;
    end else if (inf_a || zero_b) begin
      classify = SP_INF;
    end else if (zero_a || inf_b) begin
      classify = SP_ZERO;
    end else begin
      classify = SP_NONE;
    end
  endfunction

  state_e             state_q, state_d;
  spec_e              spec_q, spec_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  ediff_q, ediff_d;
  logic [23:0]        dvsr_q, dvsr_d;
  logic [25:0]        rem_q, rem_d;
  logic [25:0]        quo_q, quo_d;
  logic [31:0]        y_q, y_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [25:0]        sub_s;
  logic               ge_s;
  logic               sticky_s, guard_s, rnd_s, inc_s;
  logic [22:0]        mant_s;
  logic [23:0]        sum_s;
  logic signed [9:0]  e_pre_s, e_rnd_s;
  logic [31:0]        result_s;

  // Normalize, round and pack from the finished quotient and remainder.
  always_comb begin
    sticky_s = (rem_q != 26'd0);
    if (quo_q[25]) begin
      mant_s  = quo_q[24:2];
      guard_s = quo_q[1];
      rnd_s   = quo_q[0] | sticky_s;
      e_pre_s = ediff_q + 10'sd127;
    end else begin
      mant_s  = quo_q[23:1];
      guard_s = quo_q[0];
      rnd_s   = sticky_s;
      e_pre_s = ediff_q + 10'sd126;
    end
    inc_s   = RNE_EN & guard_s & (rnd_s | mant_s[0]);
    sum_s   = {1'b0, mant_s} + {23'd0, inc_s};
    e_rnd_s = e_pre_s + $signed({9'd0, sum_s[23]});
    case (spec_q)
      SP_NAN:  result_s = 32'h7FC0_0000;
      SP_INF:  result_s = {sign_q, 8'hFF, 23'd0};
      SP_ZERO: result_s = {sign_q, 31'd0};
      SP_NONE: begin
        if (e_rnd_s >= 10'sd255) begin
          result_s = {sign_q, 8'hFF, 23'd0};
        end else if (e_rnd_s <= 10'sd0) begin
          result_s = {sign_q, 31'd0};
        end else begin
          result_s = {sign_q, e_rnd_s[7:0], sum_s[22:0]};
        end
      end
      default: result_s = 32'h0000_0000;
    endcase
  end

  // Next-state and datapath control for the IDLE/DIV/NORM/DONE sequence.
  always_comb begin
    state_d     = state_q;
    spec_d      = spec_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    ediff_d     = ediff_q;
    dvsr_d      = dvsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    sub_s       = rem_q - {2'b00, dvsr_q};
    ge_s        = (rem_q >= {2'b00, dvsr_q});
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DIV;
          cnt_d   = 5'd25;
          sign_d  = x1[31] ^ x2[31];
          ediff_d = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]});
          dvsr_d  = {1'b1, x2[22:0]};
          rem_d   = {2'b00, 1'b1, x1[22:0]};
          quo_d   = 26'd0;
          spec_d  = classify(x1, x2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        // Partial remainder stays below the divisor after a subtract, so the shift never drops a bit.
        rem_d = ge_s ? {sub_s[24:0], 1'b0} : {rem_q[24:0], 1'b0};
        quo_d = {quo_q[24:0], ge_s};
        if (cnt_q == 5'd0) begin
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_NORM: begin
        y_d         = result_s;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      spec_q      <= SP_NONE;
      cnt_q       <= 5'd0;
      sign_q      <= 1'b0;
      ediff_q     <= 10'sd0;
      dvsr_q      <= 24'd0;
      rem_q       <= 26'd0;
      quo_q       <= 26'd0;
      y_q         <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      spec_q      <= spec_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      ediff_q     <= ediff_d;
      dvsr_q      <= dvsr_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_fdiv.sv
// Directed self-checking bench for fdiv: latency, rounding, specials, range, backpressure, reset.
module tb_fdiv;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x1, x2, y;
  logic        in_valid, in_ready, out_valid, out_ready;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fdiv dut (
    .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one operand pair; returns at the falling edge after the accepting edge.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check({tag, "_rdy_before"}, {31'd0, in_ready}, 32'd1);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_rdy_busy"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_result(input string tag);
    int edges;
    edges = 0;
    while (!out_valid && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, edges, 32'd27);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_y);
    out_ready = 1'b1;
    issue(tag, a, b);
    wait_result(tag);
    check({tag, "_y"}, y, exp_y);
    @(negedge clk);
    check({tag, "_vld_clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] y_hold;

  initial begin
    rstn = 1'b0; x1 = 32'd0; x2 = 32'd0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", y, 32'd0);
    rstn = 1'b1;

    run_op("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
`ifdef FDIV_RNE_EN
    run_op("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
`else
    run_op("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA);
`endif
    run_op("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
    run_op("zero_by_zero", 32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_op("m1_by_inf", 32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000);
    run_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000);
    run_op("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000);
    run_op("neg_ten_by_five", 32'hC120_0000, 32'h40A0_0000, 32'hC000_0000);

    // Backpressure: result must hold and a new request must be ignored.
    out_ready = 1'b0;
    issue("bp", 32'h40C0_0000, 32'h4000_0000);
    wait_result("bp");
    check("bp_y", y, 32'h4040_0000);
    y_hold = y;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        x1 = 32'h4000_0000; x2 = 32'h3F80_0000; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_y_stable", y, y_hold);
      check("bp_rdy_low", {31'd0, in_ready}, 32'd0);
      check("bp_vld_high", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_vld_clr", {31'd0, out_valid}, 32'd0);
    check("bp_rdy_back", {31'd0, in_ready}, 32'd1);
    repeat (30) @(negedge clk);
    check("bp_no_ghost_op", {31'd0, out_valid}, 32'd0);
    run_op("bp_retry", 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000);

    // Reset during DIV discards the operation.
    out_ready = 1'b0;
    issue("mid_rst", 32'h40C0_0000, 32'h4000_0000);
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    check("mid_rst_y", y, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_vld", {31'd0, out_valid}, 32'd0);
    check("post_rst_y", y, 32'd0);
    check("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    run_op("ten_by_five", 32'h4120_0000, 32'h40A0_0000, 32'h4000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
